// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: opcodes, scoreboard entry layout
// and the forwarding-select encoding used by pipe_scoreboard.
package cpu_pkg;

    // Widest register number an entry can hold; narrower NREGS zero-extend.
    localparam int DST_W_MAX = 8;

    // Opcode constants of the core ISA.
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Forwarding select value meaning "use the register file".
    localparam int FWD_RF = 0;

    // One in-flight instruction as tracked past ID.
    typedef struct packed {
        logic                 valid;
        logic [DST_W_MAX-1:0] dst;
        logic                 we;
        logic                 is_load;
        logic                 hlt;
    } sb_entry_t;

endpackage

// File: rtl/pipe_scoreboard_sb_match.sv
// sb_match: youngest-match priority encoder for one source operand.
// Entry 0 (EX) is youngest. Reports the forwarding select (k+1 of the
// youngest matching entry, FWD_RF if none) and whether that producer's
// result is not yet available (load still in EX, etc.).
module sb_match
    import cpu_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int AW       = 4,
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    localparam int SW      = $clog2(DEPTH + 1)
) (
    input  sb_entry_t [DEPTH-1:0] entries_i,
    input  logic [AW-1:0]         src_addr_i,
    input  logic                  src_en_i,
    output logic [SW-1:0]         sel_o,
    output logic                  not_ready_o
);

    logic [DEPTH-1:0] unused_hlt;
    logic             zero_src;
    int               lat;

    assign zero_src = (ZERO_REG != 0) && (src_addr_i == '0);

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel_o       = SW'(FWD_RF);
        not_ready_o = 1'b0;
        lat         = 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (src_en_i && !zero_src && entries_i[k].valid && entries_i[k].we &&
                (entries_i[k].dst == DST_W_MAX'(src_addr_i))) begin
                lat         = entries_i[k].is_load ? LOAD_LAT : ALU_LAT;
                sel_o       = SW'(k + 1);
                not_ready_o = (k < lat);
            end
        end
    end

    // The halt flag plays no part in matching.
    always_comb begin
        unused_hlt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            unused_hlt[k] = entries_i[k].hlt;
        end
    end

endmodule

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: hazard / forwarding controller beside the ID stage.
// Tracks in-flight register writes EX..WB in a shift-register scoreboard,
// drives per-source forwarding selects, the load-use stall and halt drain.
// Optional build macro SCOREBOARD_PERF_EN adds saturating 32-bit
// stall_cycles and fwd_hits counters.
module pipe_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS    = 16,
    parameter int DEPTH    = 3,
    parameter int NSRC     = 2,
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS),
    localparam int SW      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [NSRC*AW-1:0] id_src_addr,
    input  logic [NSRC-1:0]    id_src_en,
    input  logic [AW-1:0]      id_dst_addr,
    input  logic               id_dst_we,
    input  logic               id_is_load,
    input  logic               id_hlt,
    input  logic               hold,
    input  logic               flush,
    output logic               stall,
    output logic [NSRC*SW-1:0] fwd_sel,
    output logic               drained,
    output logic [SW-1:0]      occupancy
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        fwd_hits
`endif
);

    sb_entry_t [DEPTH-1:0] entry_q, entry_d;
    logic                  halt_pending_q, halt_pending_d;
    logic [NSRC-1:0]       src_not_ready;
    logic                  issue;
    sb_entry_t             new_entry;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        sb_match #(
            .DEPTH    (DEPTH),
            .AW       (AW),
            .ALU_LAT  (ALU_LAT),
            .LOAD_LAT (LOAD_LAT),
            .ZERO_REG (ZERO_REG)
        ) u_match (
            .entries_i   (entry_q),
            .src_addr_i  (id_src_addr[i*AW +: AW]),
            .src_en_i    (id_src_en[i]),
            .sel_o       (fwd_sel[i*SW +: SW]),
            .not_ready_o (src_not_ready[i])
        );
    end

    assign stall   = id_valid && !flush && (|src_not_ready);
    assign issue   = id_valid && !stall && !flush && !halt_pending_q;
    assign drained = halt_pending_q && (occupancy == '0);

    // Count valid entries.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + SW'(entry_q[k].valid);
        end
    end

    // Next scoreboard state: shift on advance, bubble or issued instr into
    // EX, flush kills the new EX and MEM entries; hold freezes everything.
    always_comb begin
        entry_d        = entry_q;
        halt_pending_d = halt_pending_q;
        new_entry      = '{valid:   issue,
                           dst:     DST_W_MAX'(id_dst_addr),
                           we:      id_dst_we,
                           is_load: id_is_load,
                           hlt:     id_hlt};
        if (!hold) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                entry_d[k] = entry_q[k-1];
            end
            entry_d[0] = issue ? new_entry : '0;
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (k <= 1) begin
                        entry_d[k].valid = 1'b0;
                    end
                end
            end
            if (issue && id_hlt) begin
                halt_pending_d = 1'b1;
            end
        end
    end

    // Scoreboard and halt state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q        <= '0;
            halt_pending_q <= 1'b0;
        end else begin
            entry_q        <= entry_d;
            halt_pending_q <= halt_pending_d;
        end
    end

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] fwd_hits_q, fwd_hits_d;

    // Saturating performance counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        fwd_hits_d     = fwd_hits_q;
        if (stall && !hold && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (issue && (fwd_sel != '0) && (fwd_hits_q != '1)) begin
            fwd_hits_d = fwd_hits_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            fwd_hits_q     <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fwd_hits_q     <= fwd_hits_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign fwd_hits     = fwd_hits_q;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Testbench for pipe_scoreboard: a list-of-in-flight-instructions reference
// model produces expected outputs each cycle into a queue; a monitor on the
// falling edge pops and compares against the DUT.
module tb_pipe_scoreboard;

    localparam int AW = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [2*AW-1:0] id_src_addr = '0;
    logic [1:0]    id_src_en = '0;
    logic [AW-1:0] id_dst_addr = '0;
    logic          id_dst_we = 1'b0;
    logic          id_is_load = 1'b0;
    logic          id_hlt = 1'b0;
    logic          hold = 1'b0;
    logic          flush = 1'b0;
    logic          stall;
    logic [2*SW-1:0] fwd_sel;
    logic          drained;
    logic [SW-1:0] occupancy;

    pipe_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_src_addr (id_src_addr),
        .id_src_en   (id_src_en),
        .id_dst_addr (id_dst_addr),
        .id_dst_we   (id_dst_we),
        .id_is_load  (id_is_load),
        .id_hlt      (id_hlt),
        .hold        (hold),
        .flush       (flush),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .drained     (drained),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid;
        int       src [2];
        bit       en  [2];
        int       dst;
        bit       we;
        bit       ld;
        bit       hlt;
    } instr_t;

    typedef struct {
        int dst;
        bit we;
        bit ld;
        int age;   // cycles since entering EX: 0 = EX, 1 = MEM, 2 = WB
    } inflight_t;

    typedef struct {
        bit stall;
        int sel [2];
        bit drained;
        int occ;
    } exp_t;

    inflight_t fl[$];
    bit        halt_pend;
    exp_t      expq[$];
    instr_t    cur;
    bit        last_issue;
    int        n_vec = 0;
    int        n_bad = 0;

    function automatic instr_t mk(bit v, int s0, int s1, bit e0, bit e1,
                                  int d, bit we, bit ld, bit hlt);
        instr_t r;
        r.valid = v; r.src[0] = s0; r.src[1] = s1; r.en[0] = e0; r.en[1] = e1;
        r.dst = d; r.we = we; r.ld = ld; r.hlt = hlt;
        return r;
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        r.valid  = ($urandom_range(9) != 0);
        r.src[0] = $urandom_range(7);
        r.src[1] = $urandom_range(7);
        r.en[0]  = ($urandom_range(4) != 0);
        r.en[1]  = ($urandom_range(2) != 0);
        r.dst    = $urandom_range(7);
        r.we     = ($urandom_range(4) != 0);
        r.ld     = ($urandom_range(2) == 0);
        r.hlt    = ($urandom_range(60) == 0);
        return r;
    endfunction

    // One clock: drive inputs, predict outputs, then step the model.
    task automatic step(input bit h, input bit f);
        exp_t      e;
        bit        nr;
        bit        iss;
        inflight_t nfl[$];
        inflight_t n;
        @(posedge clk);
        #1;
        id_valid    = cur.valid;
        id_src_addr = {AW'(cur.src[1]), AW'(cur.src[0])};
        id_src_en   = {cur.en[1], cur.en[0]};
        id_dst_addr = AW'(cur.dst);
        id_dst_we   = cur.we;
        id_is_load  = cur.ld;
        id_hlt      = cur.hlt;
        hold        = h;
        flush       = f;
        nr = 0;
        for (int i = 0; i < 2; i++) begin
            int best_age;
            bit best_ld;
            best_age = -1;
            best_ld  = 0;
            foreach (fl[j]) begin
                if (cur.en[i] && fl[j].we && fl[j].dst == cur.src[i] && cur.src[i] != 0 &&
                    (best_age < 0 || fl[j].age < best_age)) begin
                    best_age = fl[j].age;
                    best_ld  = fl[j].ld;
                end
            end
            e.sel[i] = (best_age < 0) ? 0 : best_age + 1;
            if (best_age >= 0 && best_age < (best_ld ? 1 : 0)) nr = 1;
        end
        e.stall   = rst_n && cur.valid && !f && nr;
        e.occ     = fl.size();
        e.drained = halt_pend && (fl.size() == 0);
        expq.push_back(e);
        iss = rst_n && cur.valid && !e.stall && !f && !halt_pend;
        last_issue = iss && !h;
        if (rst_n && !h) begin
            foreach (fl[j]) begin
                if (!(f && fl[j].age == 0) && fl[j].age + 1 < 3) begin
                    n = fl[j];
                    n.age++;
                    nfl.push_back(n);
                end
            end
            if (iss) begin
                n.dst = cur.dst; n.we = cur.we; n.ld = cur.ld; n.age = 0;
                nfl.push_front(n);
                if (cur.hlt) halt_pend = 1;
            end
            fl = nfl;
        end
    endtask

    task automatic set_rst(input bit v);
        @(posedge clk);
        #1;
        rst_n = v;
        if (!v) begin
            fl.delete();
            halt_pend = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare combinational outputs mid-cycle against the model.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("stall", int'(stall), int'(e.stall));
            chk("occupancy", int'(occupancy), e.occ);
            chk("drained", int'(drained), int'(e.drained));
            if (!e.stall) begin
                chk("fwd_sel0", int'(fwd_sel[1:0]), e.sel[0]);
                chk("fwd_sel1", int'(fwd_sel[3:2]), e.sel[1]);
            end
        end
    end

    instr_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        halt_pend = 0;
        cur = idle;
        // Reset state
        step(0, 0);
        step(0, 0);
        set_rst(1);

        // RAW on ALU result: ADD R1,R2,R3 ; ADD R4,R1,R1
        cur = mk(1, 2, 3, 1, 1, 1, 1, 0, 0); step(0, 0);
        cur = mk(1, 1, 1, 1, 1, 4, 1, 0, 0); step(0, 0);
        cur = idle; step(0, 0); step(0, 0); step(0, 0);

        // Load-use: LW R5,0(R6) ; ADD R7,R5,R0 (stalls one cycle)
        cur = mk(1, 6, 0, 1, 0, 5, 1, 1, 0); step(0, 0);
        cur = mk(1, 5, 0, 1, 1, 7, 1, 0, 0); step(0, 0); step(0, 0);
        cur = idle; step(0, 0); step(0, 0); step(0, 0);

        // Youngest wins: ADD R1 ; SUB R1 ; AND R2,R1,R1
        cur = mk(1, 2, 3, 1, 1, 1, 1, 0, 0); step(0, 0);
        cur = mk(1, 4, 5, 1, 1, 1, 1, 0, 0); step(0, 0);
        cur = mk(1, 1, 1, 1, 1, 2, 1, 0, 0); step(0, 0);
        cur = idle; step(0, 0); step(0, 0); step(0, 0);

        // R0 writes never forward
        cur = mk(1, 2, 3, 1, 1, 0, 1, 1, 0); step(0, 0);
        cur = mk(1, 0, 0, 1, 1, 3, 1, 0, 0); step(0, 0);
        cur = idle; step(0, 0); step(0, 0); step(0, 0);

        // Flush with three valid entries
        cur = mk(1, 0, 0, 0, 0, 1, 1, 0, 0); step(0, 0);
        cur = mk(1, 0, 0, 0, 0, 2, 1, 0, 0); step(0, 0);
        cur = mk(1, 0, 0, 0, 0, 3, 1, 0, 0); step(0, 0);
        cur = mk(1, 0, 0, 0, 0, 4, 1, 0, 0); step(0, 1);
        cur = idle; step(0, 0); step(0, 0);

        // Hold and flush together: hold wins
        cur = mk(1, 0, 0, 0, 0, 1, 1, 0, 0); step(0, 0);
        cur = mk(1, 0, 0, 0, 0, 2, 1, 0, 0); step(1, 1);
        cur = idle; step(0, 0); step(0, 0); step(0, 0);

        // HLT with two in flight, then hold for two cycles during drain
        cur = mk(1, 0, 0, 0, 0, 1, 1, 0, 0); step(0, 0);
        cur = mk(1, 0, 0, 0, 0, 2, 1, 0, 0); step(0, 0);
        cur = mk(1, 0, 0, 0, 0, 0, 0, 0, 1); step(0, 0);
        cur = mk(1, 1, 2, 1, 1, 5, 1, 0, 0); step(0, 0); step(1, 0); step(1, 0);
        for (int i = 0; i < 6; i++) step(0, 0);

        // Asynchronous reset mid-operation
        set_rst(0);
        cur = idle; step(0, 0);
        set_rst(1);

        // Randomised traffic, reset between rounds
        for (int r = 0; r < 8; r++) begin
            cur = rand_instr();
            for (int c = 0; c < 400; c++) begin
                bit h, f;
                h = ($urandom_range(9) == 0);
                f = ($urandom_range(12) == 0);
                step(h, f);
                if (last_issue || (f && !h)) cur = rand_instr();
            end
            set_rst(0);
            cur = idle; step(0, 0);
            set_rst(1);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
